// File: rtl/wb_stage_reg.sv
// rtl/wb_stage_reg.sv - MEM->WB stage register with valid/ready handshake and 2-entry skid buffer
// Optional stall-cycle counter enabled by defining WB_STAGE_REG_PERF_EN.
module wb_stage_reg #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int LANES  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_wData,
  input  logic [LANES-1:0]          in_wReg,
  input  logic [LANES*ADDR_W-1:0]   in_wRegAddr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_wData,
  output logic [LANES-1:0]          out_wReg,
  output logic [LANES*ADDR_W-1:0]   out_wRegAddr,
  output logic [1:0]                occupancy
`ifdef WB_STAGE_REG_PERF_EN
  ,
  output logic [15:0]               stall_cnt
`endif
);

  typedef struct packed {
    logic [LANES*DATA_W-1:0] data;
    logic [LANES-1:0]        wreg;
    logic [LANES*ADDR_W-1:0] addr;
  } beat_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    M_HOLD = 2'd0,
    M_IN   = 2'd1,
    M_SKID = 2'd2,
    M_CLR  = 2'd3
  } main_op_t;

  typedef enum logic [1:0] {
    K_HOLD = 2'd0,
    K_IN   = 2'd1,
    K_CLR  = 2'd2
  } skid_op_t;

  state_t   state_q, state_d;
  main_op_t main_op;
  skid_op_t skid_op;
  beat_t    main_q, skid_q, in_beat;
  logic     in_xfer, out_xfer;

  // Handshake outputs depend only on registered state.
  assign in_ready  = (state_q != S_FULL);
  assign out_valid = (state_q != S_EMPTY);
  assign occupancy = state_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  assign in_beat.data = in_wData;
  assign in_beat.wreg = in_wReg;
  assign in_beat.addr = in_wRegAddr;

  assign out_wData    = main_q.data;
  assign out_wReg     = main_q.wreg;
  assign out_wRegAddr = main_q.addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_op = M_HOLD;
    skid_op = K_HOLD;
    if (flush_i) begin
      state_d = S_EMPTY;
      main_op = M_CLR;
      skid_op = K_CLR;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_xfer) begin
            state_d = S_ONE;
            main_op = M_IN;
          end
        end
        S_ONE: begin
          if (in_xfer && out_xfer) begin
            main_op = M_IN;
          end else if (in_xfer) begin
            state_d = S_FULL;
            skid_op = K_IN;
          end else if (out_xfer) begin
            // Clearing main keeps write enables low while no beat is presented.
            state_d = S_EMPTY;
            main_op = M_CLR;
          end
        end
        S_FULL: begin
          if (out_xfer) begin
            state_d = S_ONE;
            main_op = M_SKID;
            skid_op = K_CLR;
          end
        end
        default: begin
          state_d = S_EMPTY;
          main_op = M_CLR;
          skid_op = K_CLR;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= '0;
    end else begin
      case (main_op)
        M_IN:    main_q <= in_beat;
        M_SKID:  main_q <= skid_q;
        M_CLR:   main_q <= '0;
        default: main_q <= main_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_q <= '0;
    end else begin
      case (skid_op)
        K_IN:    skid_q <= in_beat;
        K_CLR:   skid_q <= '0;
        default: skid_q <= skid_q;
      endcase
    end
  end

`ifdef WB_STAGE_REG_PERF_EN
  // Saturating count of cycles where write-back held off a presented beat; flush does not clear it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 16'h0000;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage_reg.sv
// tb/tb_wb_stage_reg.sv - scoreboard testbench for wb_stage_reg (LANES=2)
`timescale 1ns/1ps
module tb_wb_stage_reg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int LANES  = 2;

  typedef struct packed {
    logic [LANES*DATA_W-1:0] data;
    logic [LANES-1:0]        wreg;
    logic [LANES*ADDR_W-1:0] addr;
  } beat_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    flush_i;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_wData;
  logic [LANES-1:0]        in_wReg;
  logic [LANES*ADDR_W-1:0] in_wRegAddr;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] out_wData;
  logic [LANES-1:0]        out_wReg;
  logic [LANES*ADDR_W-1:0] out_wRegAddr;
  logic [1:0]              occupancy;
`ifdef WB_STAGE_REG_PERF_EN
  logic [15:0]             stall_cnt;
`endif

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];

  wb_stage_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_wData     (in_wData),
    .in_wReg      (in_wReg),
    .in_wRegAddr  (in_wRegAddr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_wData    (out_wData),
    .out_wReg     (out_wReg),
    .out_wRegAddr (out_wRegAddr),
    .occupancy    (occupancy)
`ifdef WB_STAGE_REG_PERF_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: consumes one expected beat per output transfer; bubbles must read zero.
  always @(negedge clk) begin
    if (rst && !flush_i) begin
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got beat %h expected none", out_wData);
          end else begin
            beat_t b;
            b = exp_q.pop_front();
            chk("sb_beat", {out_wData, out_wReg, out_wRegAddr}, {b.data, b.wreg, b.addr});
          end
        end
      end else begin
        chk("bubble_zero", {out_wData, out_wReg, out_wRegAddr}, 64'd0);
      end
    end
  end

  // One cycle: decide acceptance at negedge (scoreboard push), return 1ns after next posedge.
  task automatic step(output bit acc);
    beat_t b;
    @(negedge clk);
    acc = in_valid && in_ready && !flush_i && rst;
    if (acc) begin
      b.data = in_wData;
      b.wreg = in_wReg;
      b.addr = in_wRegAddr;
      exp_q.push_back(b);
    end
    if (flush_i) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic [1:0] w, input logic [7:0] a);
    in_valid    = 1'b1;
    in_wData    = d;
    in_wReg     = w;
    in_wRegAddr = a;
  endtask

  task automatic send(input string name, input logic [31:0] d, input logic [1:0] w, input logic [7:0] a);
    bit acc;
    int n;
    drive(d, w, a);
    acc = 1'b0;
    n = 0;
    while (!acc && n < 8) begin
      step(acc);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: got not accepted expected accepted", name);
    end
    in_valid = 1'b0;
  endtask

  logic [31:0] stream_d [4] = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
  logic [1:0]  stream_w [4] = '{2'b11, 2'b01, 2'b10, 2'b11};
  logic [7:0]  stream_a [4] = '{8'h12, 8'h34, 8'h56, 8'h78};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    rst = 1'b0; flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_wData = '0; in_wReg = '0; in_wRegAddr = '0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_occ", occupancy, 0);
    chk("rst_outputs", {out_wData, out_wReg, out_wRegAddr}, 64'd0);
`ifdef WB_STAGE_REG_PERF_EN
    chk("rst_stall_cnt", stall_cnt, 0);
`endif
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(stream_d[i], stream_w[i], stream_a[i]);
      step(acc);
      chk("stream_acc", acc, 1);
      chk("stream_occ", occupancy, 1);
    end
    in_valid = 1'b0;
    step(acc);
    chk("stream_drain_occ", occupancy, 0);

    // Skid: A, B, C with two cycles of back-pressure
    out_ready = 1'b0;
    drive(32'hAAAA_0001, 2'b11, 8'hA1);
    step(acc);
    chk("skid_occ1", occupancy, 1);
    drive(32'hBBBB_0002, 2'b10, 8'hB2);
    step(acc);
    chk("skid_occ2", occupancy, 2);
    chk("skid_in_ready", in_ready, 0);
    drive(32'hCCCC_0003, 2'b01, 8'hC3);
    step(acc);
    chk("skid_c_blocked", acc, 0);
    chk("skid_occ_hold", occupancy, 2);
    out_ready = 1'b1;
    step(acc);
    chk("skid_c_blocked2", acc, 0);
    chk("skid_occ_after_pop", occupancy, 1);
    step(acc);
    chk("skid_c_acc", acc, 1);
    chk("skid_occ_c", occupancy, 1);
    in_valid = 1'b0;
    step(acc);
    chk("skid_drain_occ", occupancy, 0);

    // Flush with FULL stage and a concurrent input beat D
    out_ready = 1'b0;
    send("flush_a", 32'h0A0A_0A0A, 2'b11, 8'h11);
    send("flush_b", 32'h0B0B_0B0B, 2'b11, 8'h22);
    chk("flush_full", occupancy, 2);
    drive(32'h0D0D_0D0D, 2'b11, 8'hDD);
    flush_i = 1'b1;
    step(acc);
    flush_i = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_wreg", out_wReg, 0);
    chk("flush_occ", occupancy, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(acc);
      chk("flush_no_d", out_valid, 0);
    end

    // Drain bubble
    drive(32'hCAFE_F00D, 2'b11, 8'h55);
    step(acc);
    chk("bubble_valid", out_valid, 1);
    chk("bubble_wreg_live", out_wReg, 2'b11);
    chk("bubble_addr_live", out_wRegAddr, 8'h55);
    in_valid = 1'b0;
    step(acc);
    chk("bubble_valid0", out_valid, 0);
    chk("bubble_wreg0", out_wReg, 0);
    chk("bubble_addr0", out_wRegAddr, 0);
    chk("bubble_data0", out_wData, 0);

    // Asynchronous reset mid-traffic
    out_ready = 1'b0;
    send("rst_f", 32'h0F0F_1234, 2'b01, 8'h9A);
    send("rst_g", 32'h4321_0E0E, 2'b10, 8'hBC);
    chk("rst_mid_full", occupancy, 2);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_occ", occupancy, 0);
    chk("rst_mid_outputs", {out_wData, out_wReg, out_wRegAddr}, 64'd0);
`ifdef WB_STAGE_REG_PERF_EN
    chk("rst_mid_stall_cnt", stall_cnt, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    send("post_rst", 32'h600D_BEEF, 2'b11, 8'h3C);
    step(acc);
    chk("post_rst_occ", occupancy, 0);

`ifdef WB_STAGE_REG_PERF_EN
    // Stall counter: exact count, saturation, survives flush
    out_ready = 1'b0;
    send("perf_p", 32'h5A5A_A5A5, 2'b11, 8'h77);
    repeat (10) @(posedge clk);
    #1;
    chk("perf_cnt10", stall_cnt, 16'd10);
    repeat (69990) @(posedge clk);
    #1;
    chk("perf_sat", stall_cnt, 16'hFFFF);
    flush_i = 1'b1;
    step(acc);
    flush_i = 1'b0;
    chk("perf_flush_keep", stall_cnt, 16'hFFFF);
    chk("perf_flush_empty", out_valid, 0);
`endif

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage_reg.md
# wb_stage_reg

Parametrised MEM→WB pipeline stage register for the next-generation core: carries one or more write-back lanes (data, write enable, destination register address) from the memory stage to the register file. It replaces fixed stall-vector gating with a valid/ready handshake and a 2-entry skid buffer, so upstream stalls are decoupled from downstream back-pressure without a combinational ready path. It also supports a synchronous flush and optional stall-cycle instrumentation.

## Interface
Parameters:
- DATA_W, default 16: width of one lane's write-back data.
- ADDR_W, default 4: width of one lane's destination register address.
- LANES, default 1: number of parallel write-back lanes; all lanes move together as one beat.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous, active-low.
- flush_i  in  1  synchronous flush; discards all buffered beats.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat this cycle.
- in_wData  in  LANES*DATA_W  lane data; lane k occupies bits [k*DATA_W +: DATA_W].
- in_wReg  in  LANES  per-lane write enable.
- in_wRegAddr  in  LANES*ADDR_W  per-lane destination address.
- out_valid  out  1  beat presented to write-back.
- out_ready  in  1  write-back consumes the presented beat.
- out_wData  out  LANES*DATA_W  presented lane data.
- out_wReg  out  LANES  presented write enables; all 0 whenever out_valid=0.
- out_wRegAddr  out  LANES*ADDR_W  presented addresses.
- occupancy  out  2  beats held (0, 1 or 2).
- stall_cnt  out  16  only with WB_STAGE_REG_PERF_EN; see Configuration.

## Operation
- Storage: main register (drives outputs directly) and skid register; each holds one full beat (data, wReg, wRegAddr).
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- States: EMPTY (occupancy 0), ONE (1), FULL (2). in_ready = (state != FULL); out_valid = (state != EMPTY). Both decoded from registered state only.
- EMPTY: transfer in → main ← input, ONE; otherwise stay.
- ONE: in & out → main ← input, ONE; in only → skid ← input, FULL; out only → EMPTY; neither → hold.
- FULL: input ignored (in_ready=0); out → main ← skid, ONE; otherwise hold.
- Beat order strictly preserved; no beat dropped or duplicated except by flush.
- Bubble rule: when a state change leaves main invalid (→EMPTY), main data, wReg and wRegAddr are cleared to 0, so out_wReg/out_wData/out_wRegAddr read 0 whenever out_valid=0.
- Flush: flush_i=1 at a clock edge → EMPTY, both registers cleared; any in/out transfer in that cycle is void (input beat not captured). Flush has priority over all transitions; reset has priority over flush.
- Lanes carry no inter-lane checks; duplicate addresses across lanes pass through unchanged.

## Timing
- Reset (rst=0, async): state EMPTY, out_valid=0, out_wData=0, out_wReg=0, out_wRegAddr=0, occupancy=0, in_ready=1, stall_cnt=0. Outputs take reset values immediately, without a clock edge.
- Latency: beat accepted at edge N appears on outputs after edge N (visible in cycle N+1) when stage was EMPTY or draining.
- Throughput: one beat per cycle sustained while out_ready=1.
- Back-pressure: out_ready low for one cycle with continuous input → stage reaches FULL, in_ready low the following cycle; recovers after one out transfer.
- No combinational path from any input to in_ready or out_valid; out_ready affects only next state.

## Configuration
- WB_STAGE_REG_PERF_EN defined: stall_cnt port present; increments by 1 each edge with out_valid=1 & out_ready=0; saturates at 16'hFFFF; cleared only by rst (not by flush).
- Undefined: stall_cnt port and counter absent; all other behaviour identical.

## Test plan
- Reset mid-traffic: FULL state, assert rst=0 asynchronously → outputs 0, out_valid=0, in_ready=1, occupancy=0 before next edge.
- Streaming: LANES=2, beats with wData {16'h1111,16'h2222}, {16'h3333,16'h4444}… every cycle, out_ready=1 → each appears one cycle later, in order, occupancy stays 1.
- Skid: out_ready=0 for 2 cycles while sending A, B, C → occupancy 1→2, in_ready=0, C not accepted until space; on out_ready=1 outputs A, B, C in order.
- Flush: FULL with A, B; flush_i=1 with in_valid=1 beat D → next cycle out_valid=0, out_wReg=0, occupancy=0; D never appears.
- Drain bubble: single beat wReg=1, wRegAddr=4'h5 consumed with no new input → next cycle out_wReg=0, out_wRegAddr=0, out_wData=0.
- Perf (macro defined): out_valid=1, out_ready=0 held 70000 cycles → stall_cnt=16'hFFFF; flush leaves it unchanged.
